// File: rtl/stall_fifo_pkg.sv
// Shared constants and width helpers for the stall FIFO.
// No logic; sizes derive from DEPTH and the upstream pipeline latency.
// Not applicable (no datapath).
package stall_fifo_pkg;

    // Default geometry matching the delay/alignment pipeline it sits behind.
    localparam int DEFAULT_DEPTH = 8;
    localparam int PIPE_LATENCY  = 4;

    // Pointer width: pointers wrap naturally because DEPTH is a power of two.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy needs one extra code so that "full" (count == DEPTH) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Almost-full must leave room for every word already in flight upstream
    // once the stall takes effect.
    function automatic int afull_default(input int depth);
        return depth - PIPE_LATENCY;
    endfunction

endpackage

// File: rtl/stall_fifo_mem.sv
// DEPTH x BITS register file: one synchronous write port, one asynchronous read port.
// Write visible on the read port the cycle after the write edge; read is combinational.
// No backpressure; the caller qualifies i_wr_en. Storage is intentionally not reset.
// Ports: i_clk; i_wr_en/i_wr_addr/i_wr_data write port; i_rd_addr -> o_rd_data read port.
module stall_fifo_mem
    import stall_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int BITS  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_wr_en,
    input  logic [ptr_width(DEPTH)-1:0] i_wr_addr,
    input  logic [BITS-1:0]             i_wr_data,
    input  logic [ptr_width(DEPTH)-1:0] i_rd_addr,
    output logic [BITS-1:0]             o_rd_data
);

    logic [BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/stall_fifo.sv
// FWFT buffer turning the no-backpressure pipeline output into a valid/ready stream.
// Latency: a write accepted at edge t is visible on o_rd_valid/o_rd_data after edge t.
// Backpressure: o_almost_full stalls upstream early; when full, a write is taken only alongside a read.
// Ports: i_clk, i_rst (async, active-high); i_wr_en/i_wr_data write side;
//        o_rd_valid/i_rd_ready/o_rd_data read side; o_full, o_almost_full, o_count status.
// Optional: define STALL_FIFO_ERR_FLAG_EN to add the sticky o_ovf_err overflow flag.
module stall_fifo
    import stall_fifo_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int BITS     = 8,
    parameter int AFULL_TH = afull_default(DEPTH)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_en,
    input  logic [BITS-1:0]             i_wr_data,
    output logic                        o_full,
    output logic                        o_almost_full,
    output logic                        o_rd_valid,
    input  logic                        i_rd_ready,
    output logic [BITS-1:0]             o_rd_data,
    output logic [cnt_width(DEPTH)-1:0] o_count
`ifdef STALL_FIFO_ERR_FLAG_EN
    ,
    output logic                        o_ovf_err
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             rd_valid;
    logic             rd_fire;
    logic             wr_acc;
    logic [BITS-1:0]  mem_rd_data;

    // Flags come straight from the registered count so they add no latency.
    assign full          = (count_q == CNT_W'(DEPTH));
    assign rd_valid      = (count_q != '0);
    assign o_full        = full;
    assign o_rd_valid    = rd_valid;
    assign o_almost_full = (count_q >= CNT_W'(AFULL_TH));
    assign o_count       = count_q;

    assign rd_fire = rd_valid & i_rd_ready;
    // When full, a write can still go in because the read frees the head slot this edge.
    assign wr_acc  = i_wr_en & (~full | rd_fire);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_acc, rd_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    stall_fifo_mem #(
        .DEPTH (DEPTH),
        .BITS  (BITS)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (wr_acc),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data (i_wr_data),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (mem_rd_data)
    );

    // Storage is not reset, so mask the head word to zero while empty.
    assign o_rd_data = rd_valid ? mem_rd_data : '0;

`ifdef STALL_FIFO_ERR_FLAG_EN
    logic ovf_err_q, ovf_err_d;
    logic ovf_evt;

    // A dropped write means the upstream stall came too late: sticky until reset.
    assign ovf_evt = i_wr_en & full & ~rd_fire;

    always_comb begin
        ovf_err_d = ovf_err_q | ovf_evt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
        end
    end

    assign o_ovf_err = ovf_err_q;

`ifndef SYNTHESIS
    ovf_never: assert property (@(posedge i_clk) disable iff (i_rst) !ovf_evt);
`endif
`endif

endmodule

// File: tb/tb_stall_fifo.sv
// Self-checking bench for stall_fifo: queue model checked every cycle plus directed literal checks.
module tb_stall_fifo;

    localparam int DEPTH = 8;
    localparam int BITS  = 8;

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic            wr_en    = 1'b0;
    logic            rd_ready = 1'b0;
    logic [BITS-1:0] wr_data  = '0;
    logic [BITS-1:0] rd_data;
    logic            full;
    logic            afull;
    logic            rd_valid;
    logic [3:0]      count;
`ifdef STALL_FIFO_ERR_FLAG_EN
    logic            ovf_err;
    bit              m_ovf = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    byte unsigned mq[$];
    byte unsigned rd_log[$];
    bit           m_rf;
    bit           m_wa;

    always #5 clk = ~clk;

    stall_fifo #(
        .DEPTH    (DEPTH),
        .BITS     (BITS),
        .AFULL_TH (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wr_en       (wr_en),
        .i_wr_data     (wr_data),
        .o_full        (full),
        .o_almost_full (afull),
        .o_rd_valid    (rd_valid),
        .i_rd_ready    (rd_ready),
        .o_rd_data     (rd_data),
        .o_count       (count)
`ifdef STALL_FIFO_ERR_FLAG_EN
        ,
        .o_ovf_err     (ovf_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain queue obeying the handshake rules, updated on each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
`ifdef STALL_FIFO_ERR_FLAG_EN
            m_ovf = 1'b0;
`endif
        end else begin
            m_rf = (mq.size() != 0) && rd_ready;
            m_wa = wr_en && ((mq.size() < DEPTH) || m_rf);
`ifdef STALL_FIFO_ERR_FLAG_EN
            if (wr_en && mq.size() == DEPTH && !m_rf) m_ovf = 1'b1;
`endif
            if (m_rf) begin
                rd_log.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (m_wa) mq.push_back(wr_data);
        end
    end

    // Per-cycle compare, away from the rising edge.
    always @(negedge clk) begin
        chk("valid", {31'd0, rd_valid}, {31'd0, mq.size() != 0});
        chk("data", {24'd0, rd_data}, (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0);
        chk("count", {28'd0, count}, mq.size());
        chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
        chk("afull", {31'd0, afull}, {31'd0, mq.size() >= 4});
`ifdef STALL_FIFO_ERR_FLAG_EN
        chk("ovf_err", {31'd0, ovf_err}, {31'd0, m_ovf});
`endif
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r);
        wr_en    = w;
        wr_data  = d;
        rd_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string name, input int base, input int idx, input int exp);
        if (base + idx < rd_log.size()) chk(name, rd_log[base + idx], exp);
        else chk(name, 32'hFFFF_FFFF, exp);
    endtask

    initial begin
        int base;
        byte unsigned exp_drain[9];
        exp_drain = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};

        // Reset state
        #1;
        chk("rst_valid", {31'd0, rd_valid}, 0);
        chk("rst_count", {28'd0, count}, 0);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_afull", {31'd0, afull}, 0);
        chk("rst_data", {24'd0, rd_data}, 0);
        #10;
        rst = 1'b0;

        // Three writes, no reads
        base = rd_log.size();
        step(1'b1, 8'h11, 1'b0);
        chk("first_valid", {31'd0, rd_valid}, 1);
        chk("first_data", {24'd0, rd_data}, 32'h11);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        chk("three_count", {28'd0, count}, 3);
        chk("three_head", {24'd0, rd_data}, 32'h11);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        chk_log("drain3_0", base, 0, 32'h11);
        chk_log("drain3_1", base, 1, 32'h22);
        chk_log("drain3_2", base, 2, 32'h33);
        chk("drain3_empty", {31'd0, rd_valid}, 0);

        // Fill to DEPTH, watching almost-full and full thresholds
        base = rd_log.size();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0);
            chk("fill_afull", {31'd0, afull}, {31'd0, i >= 4});
            chk("fill_full", {31'd0, full}, {31'd0, i == 8});
        end

        // Full with simultaneous write and read
        step(1'b1, 8'hAA, 1'b1);
        chk("fullrw_count", {28'd0, count}, 8);
        chk("fullrw_full", {31'd0, full}, 1);
        chk_log("fullrw_head", base, 0, 32'h01);
        chk("fullrw_newhead", {24'd0, rd_data}, 32'h02);

        // Full with write and no read: dropped
        step(1'b1, 8'hBB, 1'b0);
        chk("ovf_count", {28'd0, count}, 8);
        chk("ovf_head", {24'd0, rd_data}, 32'h02);
`ifdef STALL_FIFO_ERR_FLAG_EN
        chk("ovf_flag", {31'd0, ovf_err}, 1);
`endif
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        chk("drain_empty", {31'd0, rd_valid}, 0);
        chk("drain_len", rd_log.size() - base, 9);
        for (int i = 0; i < 9; i++) chk_log("drain_order", base, i, exp_drain[i]);

        // Empty with write and read in the same cycle
        base = rd_log.size();
        step(1'b1, 8'h5C, 1'b1);
        chk("wr_rd_empty_reads", rd_log.size() - base, 0);
        chk("wr_rd_empty_valid", {31'd0, rd_valid}, 1);
        chk("wr_rd_empty_data", {24'd0, rd_data}, 32'h5C);
        step(1'b0, 8'h00, 1'b1);
        chk_log("wr_rd_empty_out", base, 0, 32'h5C);

        // Continuous write+read across pointer wrap
        base = rd_log.size();
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
        chk("wrap_count", {28'd0, count}, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("wrap_len", rd_log.size() - base, 20);
        for (int i = 0; i < 20; i++) chk_log("wrap_order", base, i, 32'h40 + i);

        // Asynchronous reset mid-cycle
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        chk("pre_rst_count", {28'd0, count}, 3);
        wr_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, rd_valid}, 0);
        chk("async_rst_count", {28'd0, count}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef STALL_FIFO_ERR_FLAG_EN
        chk("ovf_cleared", {31'd0, ovf_err}, 0);
`endif
        step(1'b1, 8'h77, 1'b0);
        chk("post_rst_head", {24'd0, rd_data}, 32'h77);
        chk("post_rst_count", {28'd0, count}, 1);
        step(1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stall_fifo.md
Name: stall_fifo

Overview:
Synchronous first-word-fall-through buffer that sits directly downstream of the fixed-latency delay/alignment pipeline. The pipeline has no backpressure, so this block converts its enable-qualified output stream into a valid/ready stream for the consumer. An almost-full credit output is fed back to gate the upstream pipeline enable early enough that in-flight words are never lost.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.
- BITS, 8, data word width.
- AFULL_TH, 4, o_almost_full asserts when count >= AFULL_TH. Set it to DEPTH minus upstream pipeline latency.

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_wr_en  in  1  write strobe; connected to the upstream stage's enable-qualified valid.
- i_wr_data  in  BITS  write data.
- o_full  out  1  count == DEPTH.
- o_almost_full  out  1  count >= AFULL_TH; used to stall the upstream pipeline.
- o_rd_valid  out  1  head entry valid (count != 0).
- i_rd_ready  in  1  consumer accepts the head entry.
- o_rd_data  out  BITS  head entry data; 0 when empty.
- o_count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, immediate): wr_ptr=0, rd_ptr=0, count=0, o_full=0, o_almost_full=0 (assuming AFULL_TH>0), o_rd_valid=0, o_rd_data=0. Storage array is not reset.
- Reset mid-operation discards all contents. The first write after reset release is the new head.
- Handshakes:
  - rd_fire = o_rd_valid & i_rd_ready.
  - wr_acc = i_wr_en & (!o_full | rd_fire).
- Write accepted at edge t appears on o_rd_valid/o_rd_data after edge t, i.e. latency 1 cycle. There is no same-cycle bypass when empty.
- FWFT: o_rd_data is the mem[rd_ptr] contents, valid whenever count != 0. It is stable while o_rd_valid=1 and i_rd_ready=0.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update: +1 on wr_acc only, -1 on rd_fire only, unchanged on both or neither.
- Empty with i_wr_en and i_rd_ready both high: write accepted, no read (o_rd_valid=0). Count becomes 1.
- Full with i_wr_en and rd_fire: both accepted, count stays DEPTH, pointers both advance.
- Full with i_wr_en and no rd_fire: write dropped, storage and pointers unchanged. This is a system error; see the optional feature.
- i_rd_ready while empty: no effect.
- All flags are derived combinationally from the registered count; no extra latency.

Optional Feature:
Macro STALL_FIFO_ERR_FLAG_EN.
- Defined: adds output o_ovf_err (1 bit).
  - Sticky; set on the edge where i_wr_en=1, o_full=1 and rd_fire=0.
  - Cleared only by i_rst.
  - Also adds a simulation-only assertion that fires on the same condition.
- Undefined: no port, no flag logic; overflow writes are silently dropped.

Decomposition:
- Package stall_fifo_pkg holds:
  - the pointer-width and count-width helper constants, derived from DEPTH;
  - the default AFULL_TH derivation, DEPTH minus pipeline latency.
- One sub-module, stall_fifo_mem: DEPTH x BITS register file.
  - One write port, synchronous.
  - One asynchronous read port, indexed by rd_ptr.
- Pointer/count/flag control stays in the top module.

Test Plan:
- Reset then write 0x11,0x22,0x33 on consecutive cycles with i_rd_ready=0:
  - o_rd_valid rises the cycle after the first write, o_rd_data=0x11.
  - o_count=3.
- Fill to 8 entries 0x01..0x08 with i_rd_ready=0, then drain with i_rd_ready=1:
  - o_almost_full asserts at count 4; o_full at count 8.
  - Reads return 0x01..0x08 in order; o_rd_valid drops after the 8th.
- Full plus simultaneous i_wr_en=1 (0xAA) and i_rd_ready=1:
  - Head 0x01 is consumed, 0xAA enters the tail.
  - o_count stays 8, o_full stays 1.
- Full plus i_wr_en=1 (0xBB) with i_rd_ready=0:
  - 0xBB dropped; subsequent drain shows no 0xBB.
  - With STALL_FIFO_ERR_FLAG_EN, o_ovf_err=1 until reset.
- Empty with i_wr_en=1 and i_rd_ready=1 in the same cycle:
  - No read that cycle; next cycle o_rd_valid=1 with the written data.
- 20 continuous write+read cycles (pointer wrap), then assert i_rd_ready=1 and write nothing:
  - Data order is preserved across the wrap.
  - After 3 writes, async i_rst mid-cycle: o_rd_valid=0 and o_count=0 immediately.
